// File: rtl/downsample_rows_avg.sv
// Vertical 2:1 row decimator: even rows go to a line buffer, odd rows are averaged with it; output 1 cycle after odd-row beat.
// in_ready stalls only on odd rows while the output stage is full; DS_ROW_INVALID_SKIP_EN treats zero disparity as invalid.
module downsample_rows_avg #(
  parameter int IN_WIDTH  = 120,
  parameter int IN_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int XW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

  logic [XW-1:0] x;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y;
  logic          odd_row;
  logic          beat;
  logic          row_end;
  logic [7:0]    linebuf [IN_WIDTH];
  logic [7:0]    lb_rd;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    avg = sum[8:1];
`ifdef DS_ROW_INVALID_SKIP_EN
    if (a == 8'd0) avg = b;
    else if (b == 8'd0) avg = a;
`endif
  endfunction

  assign odd_row  = y[0];
  assign in_ready = odd_row ? (!out_valid || out_ready) : 1'b1;
  assign beat     = in_valid && in_ready;
  assign row_end  = (x == XW'(IN_WIDTH - 1));

  // Address of the next beat, so the synchronous read is ready when that beat presents.
  always_comb begin
    x_nxt = x;
    if (reset)     x_nxt = '0;
    else if (beat) x_nxt = row_end ? '0 : x + 1'b1;
  end

  always_ff @(posedge clk) begin
    lb_rd <= linebuf[x_nxt];
    if (!reset && beat && !odd_row) linebuf[x] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      if (beat) begin
        x <= x_nxt;
        if (row_end) y <= (y == YW'(IN_HEIGHT - 1)) ? '0 : y + 1'b1;
      end
      // Fill takes priority so a simultaneous drain and fill leaves no bubble.
      if (beat && odd_row) begin
        out_data  <= avg(lb_rd, in_data);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_downsample_rows_avg.sv
// Directed bench for downsample_rows_avg at IN_WIDTH=4, IN_HEIGHT=4.
module tb_downsample_rows_avg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  downsample_rows_avg #(.IN_WIDTH(4), .IN_HEIGHT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Mid-cycle sample of the handshake that completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) obs_q.push_back(out_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; holds one beat until accepted.
  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] t1_r0 [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] t1_r1 [4] = '{8'd12, 8'd21, 8'd33, 8'd44};
  logic [7:0] t1_e  [4] = '{8'd11, 8'd20, 8'd31, 8'd42};
  logic [7:0] t5_r0 [4] = '{8'd0, 8'd60, 8'd0, 8'd50};
  logic [7:0] t5_r1 [4] = '{8'd80, 8'd0, 8'd0, 8'd70};
  logic [7:0] t6_r0 [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
  logic [7:0] t6_r1 [4] = '{8'd3, 8'd4, 8'd200, 8'd9};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    tick(3);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    tick(1);

    // Basic pair: no output on row 0, one output per row 1 beat, one cycle later.
    for (int i = 0; i < 4; i++) push(t1_r0[i]);
    chk("t1_row0_in_ready", in_ready, 1'b1);
    chk("t1_row0_quiet", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(t1_r1[i]);
      chk("t1_lat_valid", out_valid, 1'b1);
      chk("t1_lat_data", out_data, t1_e[i]);
    end
    tick(2);
    exp_q = '{8'd11, 8'd20, 8'd31, 8'd42};
    check_out("t1_stream");

    // Saturation, then 255 against 0.
    for (int i = 0; i < 8; i++) push(8'd255);
    tick(2);
    repeat (4) exp_q.push_back(8'd255);
    check_out("t2_sat");
    for (int i = 0; i < 4; i++) push(8'd255);
    for (int i = 0; i < 4; i++) push(8'd0);
    tick(2);
`ifdef DS_ROW_INVALID_SKIP_EN
    repeat (4) exp_q.push_back(8'd255);
`else
    repeat (4) exp_q.push_back(8'd127);
`endif
    check_out("t2_zero");

    // Backpressure on an odd row.
    for (int i = 0; i < 4; i++) push(8'(100 + 2 * i));
    out_ready = 1'b0;
    push(8'd50);
    in_valid = 1'b1;
    in_data  = 8'd52;
    repeat (3) @(negedge clk);
    chk("t3_odd_in_ready", in_ready, 1'b0);
    chk("t3_hold_valid", out_valid, 1'b1);
    chk("t3_hold_data", out_data, 8'd75);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(8'd52);
    push(8'd54);
    push(8'd56);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_even_in_ready", in_ready, 1'b1);
    chk("t3_last_held", out_data, 8'd81);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick(2);
    exp_q = '{8'd75, 8'd77, 8'd79, 8'd81};
    check_out("t3_stream");

    // Two frames of ramp data; second frame must repeat the first.
    for (int f = 0; f < 2; f++)
      for (int yy = 0; yy < 4; yy++)
        for (int xx = 0; xx < 4; xx++) push(8'(4 * yy + xx));
    tick(2);
    for (int f = 0; f < 2; f++) begin
`ifdef DS_ROW_INVALID_SKIP_EN
      exp_q.push_back(8'd4);
`else
      exp_q.push_back(8'd2);
`endif
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd4);
      exp_q.push_back(8'd5);
      for (int xx = 0; xx < 4; xx++) exp_q.push_back(8'(10 + xx));
    end
    check_out("t4_ramp");

    // Zero-disparity handling.
    for (int i = 0; i < 4; i++) push(t5_r0[i]);
    for (int i = 0; i < 4; i++) push(t5_r1[i]);
    tick(2);
`ifdef DS_ROW_INVALID_SKIP_EN
    exp_q = '{8'd80, 8'd60, 8'd0, 8'd60};
`else
    exp_q = '{8'd40, 8'd30, 8'd0, 8'd60};
`endif
    check_out("t5_zero");

    // Reset in the middle of an odd row with a pending output.
    for (int i = 0; i < 4; i++) push(8'd9);
    push(8'd9);
    push(8'd9);
    out_ready = 1'b0;
    chk("t6_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_in_ready", in_ready, 1'b1);
    chk("t6_rst_data", out_data, 8'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    obs_q.delete();
    tick(1);
    for (int i = 0; i < 4; i++) push(t6_r0[i]);
    chk("t6_row0_quiet", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) push(t6_r1[i]);
    tick(2);
    exp_q = '{8'd2, 8'd3, 8'd102, 8'd8};
    check_out("t6_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
